// File: rtl/ed25519_pkg.sv
// Shared ed25519 field constants and the reducer state encoding.
package ed25519_pkg;

    localparam int unsigned RED_W  = 255;
    localparam int unsigned FOLD_C = 19;

    // 2^255 - 19
    localparam logic [RED_W-1:0] P25519 = {{(RED_W-5){1'b1}}, 5'b01101};

    typedef enum logic [1:0] {
        StIdle,
        StFold,
        StCanon,
        StOut
    } state_e;

endpackage

// File: rtl/p25519_fold_step.sv
// One combinational fold: lo + 19*hi, using 2^255 == 19 (mod p). Shift-add only.
module p25519_fold_step
    import ed25519_pkg::*;
#(
    parameter int unsigned ACC_W = 519
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             hi_zero_o
);

    logic [ACC_W-1:0] lo;
    logic [ACC_W-1:0] hi;

    assign lo        = {{(ACC_W-RED_W){1'b0}}, acc_i[RED_W-1:0]};
    assign hi        = {{RED_W{1'b0}}, acc_i[ACC_W-1:RED_W]};
    assign acc_o     = lo + (hi << 4) + (hi << 1) + hi;
    assign hi_zero_o = (acc_i[ACC_W-1:RED_W] == '0);

endmodule

// File: rtl/seq_mod_p25519_stream.sv
// Sequential x mod (2^255-19) with a data-dependent fold loop and valid/ready on both sides.
// Define SEQ_MOD_CANON_EN to add the final canonicalising subtract (result in [0, p)).
module seq_mod_p25519_stream
    import ed25519_pkg::*;
#(
    parameter int unsigned IN_W      = 514,
    parameter int unsigned MAX_FOLDS = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RED_W-1:0] mod,
    output logic [CNT_W-1:0] folds_used,
    output logic             err
);

    localparam int unsigned ACC_W = ((IN_W > 256) ? IN_W : 256) + 5;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [RED_W-1:0] mod_q, mod_d;
    logic [CNT_W-1:0] folds_q, folds_d;
    logic             err_q, err_d;

    logic [ACC_W-1:0] acc_fold;
    logic             hi_zero;

    p25519_fold_step #(
        .ACC_W(ACC_W)
    ) u_fold (
        .acc_i    (acc_q),
        .acc_o    (acc_fold),
        .hi_zero_o(hi_zero)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mod_d   = mod_q;
        folds_d = folds_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    acc_d   = ACC_W'(x);
                    folds_d = '0;
                    err_d   = 1'b0;
                    state_d = StFold;
                end
            end
            StFold: begin
                if (hi_zero || (folds_q == CNT_W'(MAX_FOLDS))) begin
                    err_d = !hi_zero;
                    // On overflow the residual hi is dropped; lo is what gets reported.
                    acc_d = {{(ACC_W-RED_W){1'b0}}, acc_q[RED_W-1:0]};
`ifdef SEQ_MOD_CANON_EN
                    state_d = StCanon;
`else
                    mod_d   = acc_q[RED_W-1:0];
                    state_d = StOut;
`endif
                end else begin
                    acc_d   = acc_fold;
                    folds_d = folds_q + 1'b1;
                end
            end
            StCanon: begin
                // acc < 2^255 < 2p here, so a single conditional subtract is enough.
                if (acc_q[RED_W-1:0] >= P25519) begin
                    mod_d = acc_q[RED_W-1:0] - P25519;
                end else begin
                    mod_d = acc_q[RED_W-1:0];
                end
                state_d = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            mod_q   <= '0;
            folds_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mod_q   <= mod_d;
            folds_q <= folds_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StOut);
    assign mod        = mod_q;
    assign folds_used = folds_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seq_mod_p25519_stream.sv
// Self-checking bench for seq_mod_p25519_stream against a plain-arithmetic reduction model.
module tb_seq_mod_p25519_stream;

    localparam int IN_W  = 514;
    localparam int ACC_W = 519;
    localparam int CNT_W = 4;
`ifdef SEQ_MOD_CANON_EN
    localparam bit CANON = 1'b1;
`else
    localparam bit CANON = 1'b0;
`endif

    logic [254:0] p_c;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_valid2;
    logic             in_ready, in_ready2;
    logic [IN_W-1:0]  x_in;
    logic             out_valid, out_valid2;
    logic             out_ready;
    logic [254:0]     mod, mod2;
    logic [CNT_W-1:0] folds_used, folds_used2;
    logic             err, err2;

    seq_mod_p25519_stream #(.IN_W(IN_W), .MAX_FOLDS(8), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .mod(mod), .folds_used(folds_used),
        .err(err)
    );

    seq_mod_p25519_stream #(.IN_W(IN_W), .MAX_FOLDS(2), .CNT_W(CNT_W)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .x(x_in),
        .out_valid(out_valid2), .out_ready(out_ready), .mod(mod2), .folds_used(folds_used2),
        .err(err2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reduction straight from the arithmetic definition: fold lo + 19*hi until hi is gone.
    function automatic void model(input logic [IN_W-1:0] xv, input int maxf,
                                  output logic [254:0] m, output int k, output bit e);
        logic [ACC_W-1:0] a;
        a = {5'b0, xv};
        k = 0;
        e = 1'b0;
        while ((a >> 255) != 0) begin
            if (k == maxf) begin
                e = 1'b1;
                break;
            end
            a = {264'b0, a[254:0]} + 19 * (a >> 255);
            k++;
        end
        if (CANON && (a[254:0] >= p_c)) m = a[254:0] - p_c;
        else m = a[254:0];
    endfunction

    logic         exp_on = 1'b0;
    logic         exp_sel = 1'b0;
    logic [254:0] exp_mod;
    int           exp_k;
    bit           exp_err;

    always @(negedge clk) begin
        if (rst_n && exp_on) begin
            if (!exp_sel && out_valid) begin
                chk("cmp_mod", ACC_W'(mod), ACC_W'(exp_mod));
                chk("cmp_folds", ACC_W'(folds_used), ACC_W'(exp_k));
                chk("cmp_err", ACC_W'(err), ACC_W'(exp_err));
                chk("cmp_in_ready_low", ACC_W'(in_ready), '0);
            end
            if (exp_sel && out_valid2) begin
                chk("cmp2_mod", ACC_W'(mod2), ACC_W'(exp_mod));
                chk("cmp2_folds", ACC_W'(folds_used2), ACC_W'(exp_k));
                chk("cmp2_err", ACC_W'(err2), ACC_W'(exp_err));
            end
        end
    end

    logic [254:0] got_mod;
    int           got_k;
    bit           got_err;

    task automatic run(input logic [IN_W-1:0] xv, input bit use2, input int hold, input bit poke);
        logic [254:0] m;
        int k, n;
        bit e;
        model(xv, use2 ? 2 : 8, m, k, e);
        @(negedge clk);
        chk("in_ready_idle", ACC_W'(use2 ? in_ready2 : in_ready), 1);
        exp_mod = m;
        exp_k   = k;
        exp_err = e;
        exp_sel = use2;
        exp_on  = 1'b1;
        x_in    = xv;
        out_ready = (hold == 0);
        if (use2) in_valid2 = 1'b1;
        else in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        n = 1;
        while (!(use2 ? out_valid2 : out_valid) && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("latency", ACC_W'(n), ACC_W'((CANON ? 3 : 2) + k));
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                x_in     = IN_W'(38);
            end
            chk("in_ready_busy", ACC_W'(in_ready), '0);
            @(negedge clk);
        end
        got_mod   = use2 ? mod2 : mod;
        got_k     = int'(use2 ? folds_used2 : folds_used);
        got_err   = use2 ? err2 : err;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_drop", ACC_W'(use2 ? out_valid2 : out_valid), '0);
        chk("in_ready_back", ACC_W'(use2 ? in_ready2 : in_ready), 1);
        exp_on = 1'b0;
    endtask

    initial begin
        logic [IN_W-1:0]  v;
        logic [IN_W-1:0]  ones;
        logic [ACC_W-1:0] golden;
        logic [254:0]     m;
        int k;
        bit e;

        p_c       = {{250{1'b1}}, 5'b01101};
        ones      = '1;
        golden    = {5'b0, ones} % {264'b0, p_c};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        x_in      = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", ACC_W'(in_ready), 1);
        chk("rst_out_valid", ACC_W'(out_valid), '0);
        chk("rst_mod", ACC_W'(mod), '0);
        chk("rst_folds", ACC_W'(folds_used), '0);
        chk("rst_err", ACC_W'(err), '0);
        rst_n = 1'b1;

        // Pin the model with hand-derived values.
        v = '0; v[255] = 1'b1;
        model(v, 8, m, k, e);
        chk("model_2p255", ACC_W'(m), 19);
        chk("model_2p255_k", ACC_W'(k), 1);
        v = '0; v[510] = 1'b1;
        model(v, 8, m, k, e);
        chk("model_2p510", ACC_W'(m), 361);
        model(ones, 8, m, k, e);
        chk("model_ones_k", ACC_W'(k), 3);
        chk("model_ones_mod", ACC_W'(m) % {264'b0, p_c}, golden);

        run('0, 1'b0, 0, 1'b0);
        chk("x0_mod", ACC_W'(got_mod), '0);
        chk("x0_folds", ACC_W'(got_k), '0);

        run(IN_W'(p_c), 1'b0, 0, 1'b0);
        chk("xp_mod", ACC_W'(got_mod), CANON ? '0 : ACC_W'(p_c));
        chk("xp_folds", ACC_W'(got_k), '0);

        v = '0; v[255] = 1'b1;
        run(v, 1'b0, 0, 1'b0);
        chk("x2p255_mod", ACC_W'(got_mod), 19);
        chk("x2p255_folds", ACC_W'(got_k), 1);

        v = '0; v[510] = 1'b1;
        run(v, 1'b0, 0, 1'b0);
        chk("x2p510_mod", ACC_W'(got_mod), 361);
        chk("x2p510_folds", ACC_W'(got_k), 2);

        run(ones, 1'b0, 0, 1'b0);
        if (CANON) chk("ones_mod", ACC_W'(got_mod), golden);
        else chk("ones_mod_congruent", ACC_W'(got_mod) % {264'b0, p_c}, golden);
        chk("ones_folds", ACC_W'(got_k), 3);
        chk("ones_err", ACC_W'(got_err), '0);

        run(ones, 1'b1, 0, 1'b0);
        chk("maxf2_err", ACC_W'(got_err), 1);
        chk("maxf2_folds", ACC_W'(got_k), 2);

        v = '0; v[255] = 1'b1; v[2:0] = 3'd5;
        run(v, 1'b0, 5, 1'b1);
        chk("hold_mod", ACC_W'(got_mod), 24);
        chk("hold_folds", ACC_W'(got_k), 1);

        // Reset while folding: transaction is dropped.
        @(negedge clk);
        x_in     = ones;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", ACC_W'(in_ready), 1);
        chk("midrst_out_valid", ACC_W'(out_valid), '0);
        chk("midrst_mod", ACC_W'(mod), '0);
        chk("midrst_folds", ACC_W'(folds_used), '0);

        run(IN_W'(38), 1'b0, 0, 1'b0);
        chk("x38_mod", ACC_W'(got_mod), 38);
        chk("x38_folds", ACC_W'(got_k), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
